// File: rtl/wait_pkg.sv
// Shared types and constants for the wait-state generator.
// Optional external-wait support is selected with WAIT_GEN_EXT_WAIT_EN.
package wait_pkg;

    localparam int WAIT_CNT_W      = 8;
    localparam int WAIT0_TICKS_DEF = 24;
    localparam int WAIT1_TICKS_DEF = 48;
    localparam int EXT_TIMEOUT_DEF = 192;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        EXTEND  = 2'd2,
        DONE    = 2'd3
    } wait_state_t;

endpackage

// File: rtl/wait_gen_if.sv
// CPU-side bus seen by the wait-state generator; nEXTWAIT exists only
// when WAIT_GEN_EXT_WAIT_EN is defined.
interface wait_gen_if;
    // Handshake: a select is sampled on Q rise. nWAIT low asks the clock block
    // to hold E high; the clock block must not drop E until nWAIT returns high.
    logic nE;
    logic nQ;
    logic nSEL0;
    logic nSEL1;
`ifdef WAIT_GEN_EXT_WAIT_EN
    logic nEXTWAIT;
`endif
    logic nWAIT;
    logic TIMEOUT;

    modport master (
        output nE, nQ, nSEL0, nSEL1,
`ifdef WAIT_GEN_EXT_WAIT_EN
        output nEXTWAIT,
`endif
        input  nWAIT, TIMEOUT
    );

    modport slave (
        input  nE, nQ, nSEL0, nSEL1,
`ifdef WAIT_GEN_EXT_WAIT_EN
        input  nEXTWAIT,
`endif
        output nWAIT, TIMEOUT
    );

endinterface

// File: rtl/edge_det.sv
// Registered edge detector for a signal already synchronous to i_clk.
// RISE=1 flags 0->1, RISE=0 flags 1->0.
module edge_det #(
    parameter bit RISE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sig;
    logic r_armed;

    // r_armed masks the first cycle after reset so a level already present
    // at release is not mistaken for a fresh edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig   <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_sig   <= i_sig;
            r_armed <= 1'b1;
        end
    end

    assign o_edge = RISE ? (r_armed & ~r_sig &  i_sig)
                         : (r_armed &  r_sig & ~i_sig);

endmodule

// File: rtl/wait_gen.sv
// Wait-state generator: stretches E for slow-device selects via nWAIT.
// Define WAIT_GEN_EXT_WAIT_EN to add nEXTWAIT extension and TIMEOUT.
module wait_gen
    import wait_pkg::*;
#(
    parameter int WAIT0_TICKS = WAIT0_TICKS_DEF,
    parameter int WAIT1_TICKS = WAIT1_TICKS_DEF,
    parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
    input  logic        MHZ48,
    input  logic        nRESET,
    wait_gen_if.slave   bus,
    output wait_state_t o_dbg_state
);

    if ((WAIT0_TICKS < 1) || (WAIT0_TICKS > 255)) begin : g_bad_wait0
        $error("WAIT0_TICKS must be 1..255");
    end
    if ((WAIT1_TICKS < 1) || (WAIT1_TICKS > 255)) begin : g_bad_wait1
        $error("WAIT1_TICKS must be 1..255");
    end
    if ((EXT_TIMEOUT < 1) || (EXT_TIMEOUT > 255)) begin : g_bad_ext
        $error("EXT_TIMEOUT must be 1..255");
    end

    localparam logic [WAIT_CNT_W-1:0] LOAD0 = WAIT_CNT_W'(WAIT0_TICKS - 1);
    localparam logic [WAIT_CNT_W-1:0] LOAD1 = WAIT_CNT_W'(WAIT1_TICKS - 1);

    logic w_q_rise;
    logic w_e_fall;

    // Q rise is nQ 1->0; E fall is nE 0->1.
    edge_det #(.RISE(1'b0)) u_q_edge (
        .i_clk   (MHZ48),
        .i_rst_n (nRESET),
        .i_sig   (bus.nQ),
        .o_edge  (w_q_rise)
    );

    edge_det #(.RISE(1'b1)) u_e_edge (
        .i_clk   (MHZ48),
        .i_rst_n (nRESET),
        .i_sig   (bus.nE),
        .o_edge  (w_e_fall)
    );

    wait_state_t           r_state;
    wait_state_t           w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic                  r_nwait;
    logic                  w_nwait_nxt;
`ifdef WAIT_GEN_EXT_WAIT_EN
    localparam logic [WAIT_CNT_W-1:0] LOADE = WAIT_CNT_W'(EXT_TIMEOUT - 1);
    logic [WAIT_CNT_W-1:0] r_ext_cnt;
    logic [WAIT_CNT_W-1:0] w_ext_cnt_nxt;
    logic                  r_timeout;
    logic                  w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nwait_nxt = r_nwait;
`ifdef WAIT_GEN_EXT_WAIT_EN
        w_ext_cnt_nxt = r_ext_cnt;
        w_timeout_nxt = r_timeout;
`endif
        case (r_state)
            IDLE: begin
                if (w_q_rise && (!bus.nSEL1 || !bus.nSEL0)) begin
                    w_cnt_nxt   = !bus.nSEL1 ? LOAD1 : LOAD0;
                    w_nwait_nxt = 1'b0;
                    w_state_nxt = STRETCH;
                end
            end
            STRETCH: begin
                if (r_cnt == '0) begin
`ifdef WAIT_GEN_EXT_WAIT_EN
                    if (!bus.nEXTWAIT) begin
                        w_ext_cnt_nxt = LOADE;
                        w_state_nxt   = EXTEND;
                    end else begin
                        w_nwait_nxt = 1'b1;
                        w_state_nxt = DONE;
                    end
`else
                    w_nwait_nxt = 1'b1;
                    w_state_nxt = DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
`ifdef WAIT_GEN_EXT_WAIT_EN
            EXTEND: begin
                if (bus.nEXTWAIT) begin
                    w_nwait_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_ext_cnt == '0) begin
                    w_nwait_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end else begin
                    w_ext_cnt_nxt = r_ext_cnt - 1'b1;
                end
            end
`endif
            DONE: begin
                // Held until E falls so a lingering select cannot re-trigger.
                if (w_e_fall) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_nwait_nxt = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge MHZ48 or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_nwait <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_nwait <= w_nwait_nxt;
        end
    end

`ifdef WAIT_GEN_EXT_WAIT_EN
    always_ff @(posedge MHZ48 or negedge nRESET) begin
        if (!nRESET) begin
            r_ext_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_ext_cnt <= w_ext_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.TIMEOUT = r_timeout;
`else
    assign bus.TIMEOUT = 1'b0;
`endif

    assign bus.nWAIT   = r_nwait;
    assign o_dbg_state = r_state;

endmodule

// File: doc/wait_gen.md
WAIT_GEN -- requirements
Module: wait_gen

Interface
REQ-001 Parameter WAIT0_TICKS, default 24: nWAIT low time for class-0 selects, in MHZ48 periods (24 = 500 ns).
REQ-002 Parameter WAIT1_TICKS, default 48: nWAIT low time for class-1 selects, in MHZ48 periods.
REQ-003 Parameter EXT_TIMEOUT, default 192: maximum additional MHZ48 periods nEXTWAIT may extend a wait; used only with WAIT_EXT_EN.
REQ-004 MHZ48  in  1  sole clock, 48 MHz; all logic on its rising edge.
REQ-005 nRESET  in  1  asynchronous, active-low reset.
REQ-006 nE  in  1  inverted CPU E clock from the clock block, synchronous to MHZ48.
REQ-007 nQ  in  1  inverted CPU Q clock from the clock block, synchronous to MHZ48.
REQ-008 nSEL0  in  1  active-low class-0 slow-device select, valid by Q rise.
REQ-009 nSEL1  in  1  active-low class-1 slow-device select, valid by Q rise.
REQ-010 nEXTWAIT  in  1  active-low device wait request; present only with WAIT_EXT_EN.
REQ-011 nWAIT  out  1  registered active-low stretch request to the clock block.
REQ-012 TIMEOUT  out  1  registered high-true sticky flag: external wait was cut off by EXT_TIMEOUT.

Function
REQ-013 nE/nQ are already synchronous to MHZ48 and SHALL NOT be resynchronised; each SHALL be registered once for edge detection.
- Q rise = nQ 1->0 in the registered-versus-current comparison; E fall = nE 0->1.
REQ-014 FSM states: IDLE, STRETCH, EXTEND, DONE.
REQ-015 IDLE: on Q rise with nSEL1=0, load counter with WAIT1_TICKS-1, drive nWAIT=0 on the next edge, go STRETCH.
- Otherwise, with nSEL0=0, load WAIT0_TICKS-1 and act the same way.
- With neither select, stay IDLE.
REQ-016 Both selects low together: class 1 wins.
REQ-017 STRETCH: decrement each MHZ48 edge; nWAIT stays low for exactly WAITn_TICKS periods.
- At count 0 without WAIT_EXT_EN: go DONE, nWAIT=1.
REQ-018 DONE: nWAIT=1; go IDLE on E fall only, so at most one stretch is issued per E cycle even if a select stays low.
REQ-019 Select deassertion during STRETCH SHALL NOT shorten the stretch.
REQ-020 Counter width is 8 bits; all parameters SHALL be 1..255 (elaboration error otherwise).
REQ-021 E fall during STRETCH or EXTEND SHALL be ignored; the clock block cannot drop E while nWAIT is low.

Reset
REQ-022 nRESET low SHALL immediately force: state IDLE, nWAIT=1, TIMEOUT=0, counters 0, edge registers 1.
REQ-023 Reset during STRETCH SHALL release nWAIT asynchronously.
- After reset release, the first stretch is taken only on a fresh Q rise.

Configuration
REQ-024 Macro WAIT_GEN_EXT_WAIT_EN defined: port nEXTWAIT, state EXTEND and the TIMEOUT logic are compiled in.
REQ-025 With the macro, at STRETCH count 0 and nEXTWAIT=0: go EXTEND, nWAIT stays low.
- EXTEND releases, going DONE, on the first edge where nEXTWAIT=1.
- After EXT_TIMEOUT periods in EXTEND it releases instead and sets TIMEOUT=1; only reset clears TIMEOUT.
REQ-026 Without the macro: no nEXTWAIT port, EXTEND unreachable/absent, TIMEOUT tied 0.

Structure
REQ-027 The shared package wait_pkg SHALL hold:
- the FSM state enum;
- counter width constant WAIT_CNT_W=8;
- the default tick constants.
REQ-028 A sub-module edge_det (registered 1->0 / 0->1 detector) SHALL be instantiated for nE and nQ; no other sub-modules.

Verification
REQ-029 Q rise with nSEL0=0, defaults -> nWAIT low exactly 24 MHZ48 periods starting one edge after the Q rise.
REQ-030 nSEL0=0 and nSEL1=0 together -> nWAIT low 48 periods.
REQ-031 nSEL0 held low across two Q rises in one E cycle -> one stretch only; the next E cycle yields a second stretch.
REQ-032 nRESET pulsed low 10 periods into a class-1 stretch -> nWAIT=1 within the same period, no stretch until the next Q rise.
REQ-033 Macro on, nEXTWAIT low 30 periods past the stretch end -> total nWAIT low 24+30 periods, TIMEOUT=0.
- Macro on, nEXTWAIT stuck low -> release after 24+192 periods, TIMEOUT=1 until reset.
REQ-034 No select for 1000 E cycles -> nWAIT constantly 1.
